// File: rtl/d_reg_pipe_pkg.sv
// Shared definitions for the d_reg_pipe elastic register pipeline.
// Provides the occupancy counter width helper used by the top level.
package d_reg_pipe_pkg;

    // Enough bits to count from 0 up to and including `stages`.
    function automatic int occ_width(input int stages);
        return $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/d_reg_stage.sv
// One elastic pipeline stage: a data register plus its valid bit.
// Loads on advance when the upstream source is valid; flush clears only the valid bit.
module d_reg_stage #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_adv,
    input  logic             i_src_valid,
    input  logic [WIDTH-1:0] i_src_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_vld
);

    logic [WIDTH-1:0] r_data;
    logic             r_vld;

    // NOTE: sequential state uses non-blocking assignments so every stage samples
    // its upstream neighbour's pre-edge value, which is what makes the chain shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= RST_VAL;
            r_vld  <= 1'b0;
        end else if (i_flush) begin
            r_vld <= 1'b0;
        end else if (i_adv) begin
            r_vld <= i_src_valid;
            // Data holds when a bubble moves in, so q stays stable while q_valid is low.
            if (i_src_valid) begin
                r_data <= i_src_data;
            end
        end
    end

    assign o_data = r_data;
    assign o_vld  = r_vld;

endmodule

// File: rtl/d_reg_pipe.sv
// Elastic STAGES-deep register pipeline with valid/ready handshake, bubble collapse and flush.
// Define D_REG_PIPE_OCC_EN to add the registered occupancy output `occ`.
module d_reg_pipe
    import d_reg_pipe_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter int               STAGES  = 3,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic             d_ready,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    input  logic             q_ready
`ifdef D_REG_PIPE_OCC_EN
    ,
    output logic [occ_width(STAGES)-1:0] occ
`endif
);

    logic [STAGES-1:0] w_vld;
    logic [STAGES-1:0] w_adv;
    logic [STAGES-1:0] w_src_valid;
    logic [WIDTH-1:0]  w_data     [STAGES];
    logic [WIDTH-1:0]  w_src_data [STAGES];

    // A stage may move when it is empty or everything downstream of it moves.
    always_comb begin
        w_adv[STAGES-1] = !w_vld[STAGES-1] | q_ready;
        for (int i = STAGES - 2; i >= 0; i--) begin
            w_adv[i] = !w_vld[i] | w_adv[i+1];
        end
    end

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign w_src_valid[i] = d_valid & !flush;
            assign w_src_data[i]  = d;
        end else begin : g_body
            assign w_src_valid[i] = w_vld[i-1];
            assign w_src_data[i]  = w_data[i-1];
        end

        d_reg_stage #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL)
        ) u_stage (
            .clk         (clk),
            .rst         (rst),
            .i_flush     (flush),
            .i_adv       (w_adv[i]),
            .i_src_valid (w_src_valid[i]),
            .i_src_data  (w_src_data[i]),
            .o_data      (w_data[i]),
            .o_vld       (w_vld[i])
        );
    end

    assign d_ready = w_adv[0] & !flush;
    assign q       = w_data[STAGES-1];
    assign q_valid = w_vld[STAGES-1];

`ifdef D_REG_PIPE_OCC_EN
    localparam int OCC_W = occ_width(STAGES);

    logic [OCC_W-1:0] r_occ;
    logic             w_in_hs;
    logic             w_out_hs;

    assign w_in_hs  = d_valid & d_ready;
    assign w_out_hs = q_valid & q_ready;

    // Tracks popcount(w_vld) incrementally; never exceeds STAGES since d_ready gates pushes.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_occ <= '0;
        end else if (w_in_hs && !w_out_hs) begin
            r_occ <= r_occ + OCC_W'(1);
        end else if (!w_in_hs && w_out_hs) begin
            r_occ <= r_occ - OCC_W'(1);
        end
    end

    assign occ = r_occ;
`endif

endmodule

// File: tb/tb_d_reg_pipe.sv
// Directed bench for d_reg_pipe: a WIDTH=8/STAGES=3 instance plus a WIDTH=1/STAGES=1/RST_VAL=1 instance.
// Occupancy checks are compiled in when D_REG_PIPE_OCC_EN is defined.
module tb_d_reg_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance: WIDTH=8, STAGES=3, RST_VAL=0
    logic       rst, flush, d_valid, d_ready, q_valid, q_ready;
    logic [7:0] d, q;
    // Single-stage instance: WIDTH=1, STAGES=1, RST_VAL=1
    logic       rst1, flush1, d_valid1, d_ready1, q_valid1, q_ready1;
    logic [0:0] d1, q1;
`ifdef D_REG_PIPE_OCC_EN
    logic [1:0] occ;
    logic [0:0] occ1;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    d_reg_pipe #(.WIDTH(8), .STAGES(3), .RST_VAL(8'h00)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .d       (d),
        .d_valid (d_valid),
        .d_ready (d_ready),
        .q       (q),
        .q_valid (q_valid),
        .q_ready (q_ready)
`ifdef D_REG_PIPE_OCC_EN
        ,
        .occ     (occ)
`endif
    );

    d_reg_pipe #(.WIDTH(1), .STAGES(1), .RST_VAL(1'b1)) u_dut1 (
        .clk     (clk),
        .rst     (rst1),
        .flush   (flush1),
        .d       (d1),
        .d_valid (d_valid1),
        .d_ready (d_ready1),
        .q       (q1),
        .q_valid (q_valid1),
        .q_ready (q_ready1)
`ifdef D_REG_PIPE_OCC_EN
        ,
        .occ     (occ1)
`endif
    );

    // One cycle of directed stimulus and the expected combinational view during it.
    typedef struct packed {
        logic       dv;
        logic [7:0] d;
        logic       qr;
        logic       fl;
        logic       rdy;
        logic       v;
        logic [7:0] q;
    } vec_t;

    // A1, two idle cycles, A2, A3 with the consumer stalled; A4 must be refused once full.
    vec_t bp_tbl [10] = '{
        '{1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00},
        '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00},
        '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00},
        '{1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA1},
        '{1'b1, 8'hA3, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA1},
        '{1'b1, 8'hA4, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA1},
        '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA1},
        '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA2},
        '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA3},
        '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00}
    };

    // Fill with B1..B3, flush while delivering B1 and offering 0x55, then send 0x66 through.
    vec_t fl_tbl [10] = '{
        '{1'b1, 8'hB1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00},
        '{1'b1, 8'hB2, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00},
        '{1'b1, 8'hB3, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00},
        '{1'b1, 8'h55, 1'b1, 1'b1, 1'b0, 1'b1, 8'hB1},
        '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00},
        '{1'b1, 8'h66, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00},
        '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00},
        '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00},
        '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h66},
        '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00}
    };

    // C1, C2 loaded; then C3 accepted in the same cycle C1 is delivered (occupancy stays 2).
    vec_t sim_tbl [8] = '{
        '{1'b1, 8'hC1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00},
        '{1'b1, 8'hC2, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00},
        '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00},
        '{1'b1, 8'hC3, 1'b1, 1'b0, 1'b1, 1'b1, 8'hC1},
        '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hC2},
        '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00},
        '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hC3},
        '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00}
    };

    // Advance past the next rising edge; registered outputs are stable 1 ns later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; d_valid = 1'b0; d = 8'h00; q_ready = 1'b0;
        rst1 = 1'b1; flush1 = 1'b0; d_valid1 = 1'b0; d1 = 1'b0; q_ready1 = 1'b0;
        repeat (2) cyc();
        rst = 1'b0; rst1 = 1'b0;
        #1;
        n_tests++;
        if (q_valid !== 1'b0 || q !== 8'h00 || d_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_init got v=%0b q=%h rdy=%0b exp v=0 q=00 rdy=1", q_valid, q, d_ready);
        end
        n_tests++;
        if (q_valid1 !== 1'b0 || q1 !== 1'b1 || d_ready1 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_single got v=%0b q=%0b rdy=%0b exp v=0 q=1 rdy=1", q_valid1, q1, d_ready1);
        end
        cyc();
        // Push two words, then reset mid-stream.
        d_valid = 1'b1; d = 8'h11;
        cyc();
        d = 8'h22;
        cyc();
        d_valid = 1'b0; rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        n_tests++;
        if (q_valid !== 1'b0 || q !== 8'h00 || d_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_midstream got v=%0b q=%h rdy=%0b exp v=0 q=00 rdy=1", q_valid, q, d_ready);
        end
`ifdef D_REG_PIPE_OCC_EN
        n_tests++;
        if (occ !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_occ got %0d exp 0", occ);
        end
`endif
        // The discarded words must never surface.
        q_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_tests++;
            if (q_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_drain c%0d got v=%0b q=%h exp v=0", c, q_valid, q);
            end
            cyc();
        end
    endtask

    task automatic test_streaming();
        logic       exp_v;
        logic [7:0] exp_q;
        q_ready = 1'b1;
        for (int k = 0; k < 14; k++) begin
            d_valid = (k < 10);
            d       = 8'(k + 1);
            #1;
            if (k < 10) begin
                n_tests++;
                if (d_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stream_ready k%0d got %0b exp 1", k, d_ready);
                end
            end
            exp_v = (k >= 3) && (k < 13);
            exp_q = 8'(k - 2);
            n_tests++;
            if (q_valid !== exp_v || (exp_v && q !== exp_q)) begin
                n_fail++;
                $display("FAIL stream_out k%0d got v=%0b q=%h exp v=%0b q=%h", k, q_valid, q, exp_v, exp_q);
            end
            cyc();
        end
        d_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        for (int c = 0; c < 10; c++) begin
            d_valid = bp_tbl[c].dv; d = bp_tbl[c].d; q_ready = bp_tbl[c].qr; flush = bp_tbl[c].fl;
            #1;
            n_tests++;
            if (d_ready !== bp_tbl[c].rdy || q_valid !== bp_tbl[c].v || (bp_tbl[c].v && q !== bp_tbl[c].q)) begin
                n_fail++;
                $display("FAIL backpressure c%0d got rdy=%0b v=%0b q=%h exp rdy=%0b v=%0b q=%h",
                         c, d_ready, q_valid, q, bp_tbl[c].rdy, bp_tbl[c].v, bp_tbl[c].q);
            end
`ifdef D_REG_PIPE_OCC_EN
            if (c == 5) begin
                n_tests++;
                if (occ !== 2'd3) begin
                    n_fail++;
                    $display("FAIL backpressure_occ got %0d exp 3", occ);
                end
            end
`endif
            cyc();
        end
    endtask

    task automatic test_flush();
        for (int c = 0; c < 10; c++) begin
            d_valid = fl_tbl[c].dv; d = fl_tbl[c].d; q_ready = fl_tbl[c].qr; flush = fl_tbl[c].fl;
            #1;
            n_tests++;
            if (d_ready !== fl_tbl[c].rdy || q_valid !== fl_tbl[c].v || (fl_tbl[c].v && q !== fl_tbl[c].q)) begin
                n_fail++;
                $display("FAIL flush c%0d got rdy=%0b v=%0b q=%h exp rdy=%0b v=%0b q=%h",
                         c, d_ready, q_valid, q, fl_tbl[c].rdy, fl_tbl[c].v, fl_tbl[c].q);
            end
`ifdef D_REG_PIPE_OCC_EN
            if (c == 4) begin
                n_tests++;
                if (occ !== 2'd0) begin
                    n_fail++;
                    $display("FAIL flush_occ got %0d exp 0", occ);
                end
            end
`endif
            cyc();
        end
        flush = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 8; c++) begin
            d_valid = sim_tbl[c].dv; d = sim_tbl[c].d; q_ready = sim_tbl[c].qr; flush = sim_tbl[c].fl;
            #1;
            n_tests++;
            if (d_ready !== sim_tbl[c].rdy || q_valid !== sim_tbl[c].v || (sim_tbl[c].v && q !== sim_tbl[c].q)) begin
                n_fail++;
                $display("FAIL back_to_back c%0d got rdy=%0b v=%0b q=%h exp rdy=%0b v=%0b q=%h",
                         c, d_ready, q_valid, q, sim_tbl[c].rdy, sim_tbl[c].v, sim_tbl[c].q);
            end
`ifdef D_REG_PIPE_OCC_EN
            if (c == 3 || c == 4) begin
                n_tests++;
                if (occ !== 2'd2) begin
                    n_fail++;
                    $display("FAIL back_to_back_occ c%0d got %0d exp 2", c, occ);
                end
            end
`endif
            cyc();
        end
        d_valid = 1'b0;
    endtask

    // Capacity-1 scoreboard: ready when not flushing and either empty or draining.
    task automatic test_single_stage();
        logic model_q [$];
        logic exp_v, exp_rdy;
        for (int c = 0; c < 1000; c++) begin
            d_valid1 = 1'($urandom_range(0, 1));
            d1       = 1'($urandom_range(0, 1));
            q_ready1 = 1'($urandom_range(0, 1));
            flush1   = ($urandom_range(0, 15) == 0);
            #1;
            exp_v   = (model_q.size() > 0);
            exp_rdy = !flush1 && (!exp_v || q_ready1);
            n_tests++;
            if (q_valid1 !== exp_v || d_ready1 !== exp_rdy || (exp_v && q1 !== model_q[0])) begin
                n_fail++;
                $display("FAIL single c%0d got v=%0b rdy=%0b q=%0b exp v=%0b rdy=%0b q=%0b",
                         c, q_valid1, d_ready1, q1, exp_v, exp_rdy, exp_v ? model_q[0] : 1'b0);
            end
`ifdef D_REG_PIPE_OCC_EN
            n_tests++;
            if (occ1 !== 1'(model_q.size())) begin
                n_fail++;
                $display("FAIL single_occ c%0d got %0d exp %0d", c, occ1, model_q.size());
            end
`endif
            if (flush1) begin
                model_q.delete();
            end else begin
                if (exp_v && q_ready1) void'(model_q.pop_front());
                if (d_valid1 && exp_rdy) model_q.push_back(d1[0]);
            end
            cyc();
        end
        d_valid1 = 1'b0; flush1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_back_to_back();
        test_single_stage();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
